// File: rtl/c_writeback.sv
// c_writeback: drains TPU result tiles into the C buffer.
// Each C_wr_en push stores four 128-bit rows as one entry of a 2-deep tile FIFO.
// The head entry is written out one row per accepted beat at an auto-incrementing index.
module c_writeback #(
  parameter int unsigned IDX_W     = 19,
  parameter int unsigned TILE_ROWS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] C_BASE,
  input  logic [12:0]      M_ROUND,
  input  logic             C_wr_en,
  input  logic [127:0]     C_data_in0,
  input  logic [127:0]     C_data_in1,
  input  logic [127:0]     C_data_in2,
  input  logic [127:0]     C_data_in3,
  input  logic             cbuf_ready,
  output logic             cbuf_wr_en,
  output logic [IDX_W-1:0] cbuf_index,
  output logic [127:0]     cbuf_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned LastRowInt = TILE_ROWS - 1;
  localparam logic [1:0]  LastRow    = LastRowInt[1:0];

  typedef enum logic {StIdle, StArmed} state_e;

  state_e           state_q, state_d;
  logic [511:0]     mem [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [1:0]       row_q, row_d;
  logic [IDX_W-1:0] wp_q, wp_d;
  logic [12:0]      tile_q, tile_d;
  logic [12:0]      target_q, target_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             armed, beat, pop, push_ok, push_drop, finish, arm;
  logic [12:0]      tile_next;
  logic [511:0]     head;

  // Handshake decode, datapath selection and next-state computation.
  always_comb begin
    armed     = (state_q == StArmed);
    arm       = (state_q == StIdle) && in_valid;
    cbuf_wr_en = armed && (count_q != 2'd0);
    beat      = cbuf_wr_en && cbuf_ready;
    pop       = beat && (row_q == LastRow);
    // A full FIFO can only take a push when the head frees in the same cycle.
    push_ok   = C_wr_en && armed && ((count_q != 2'd2) || pop);
    push_drop = C_wr_en && !push_ok;
    tile_next = tile_q + 13'd1;
    finish    = pop && (tile_next == target_q);
    head      = mem[rd_ptr_q];
    // Data is gated so the port reads zero whenever no write is offered.
    cbuf_data = cbuf_wr_en ? head[row_q*128 +: 128] : 128'd0;

    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    row_d    = row_q;
    wp_d     = wp_q;
    tile_d   = tile_q;
    target_d = target_q;
    done_d   = 1'b0;
    err_d    = err_q;

    if (arm) begin
      wp_d     = C_BASE;
      target_d = M_ROUND;
      tile_d   = 13'd0;
      err_d    = 1'b0;
      if (M_ROUND == 13'd0) begin
        done_d = 1'b1;
      end else begin
        state_d = StArmed;
      end
    end

    if (beat) begin
      wp_d  = wp_q + IDX_W'(1);
      row_d = row_q + 2'd1;
    end

    if (push_ok) wr_ptr_d = ~wr_ptr_q;
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      tile_d   = tile_next;
    end

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Any surplus tiles still queued at completion are discarded.
    if (finish) begin
      state_d  = StIdle;
      done_d   = 1'b1;
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      row_d    = 2'd0;
    end

    if (push_drop) err_d = 1'b1;
  end

  // Control and counter state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      row_q    <= 2'd0;
      wp_q     <= '0;
      tile_q   <= 13'd0;
      target_q <= 13'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      row_q    <= row_d;
      wp_q     <= wp_d;
      tile_q   <= tile_d;
      target_q <= target_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Tile storage; contents are only observed through the gated read path.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr_q] <= {C_data_in3, C_data_in2, C_data_in1, C_data_in0};
    end
  end

  assign cbuf_index = wp_q;
  assign busy       = armed;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_c_writeback.sv
// Directed self-checking bench for c_writeback.
module tb_c_writeback;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [18:0]  C_BASE;
  logic [12:0]  M_ROUND;
  logic         C_wr_en;
  logic [127:0] C_data_in0, C_data_in1, C_data_in2, C_data_in3;
  logic         cbuf_ready;
  logic         cbuf_wr_en;
  logic [18:0]  cbuf_index;
  logic [127:0] cbuf_data;
  logic         busy, done, err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_beat_cyc = 0;

  logic [18:0]  idx_q[$];
  logic [127:0] dat_q[$];
  logic         stall_prev = 1'b0;
  logic [18:0]  stall_idx;
  logic [127:0] stall_dat;

  c_writeback #(.IDX_W(19), .TILE_ROWS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .C_BASE     (C_BASE),
    .M_ROUND    (M_ROUND),
    .C_wr_en    (C_wr_en),
    .C_data_in0 (C_data_in0),
    .C_data_in1 (C_data_in1),
    .C_data_in2 (C_data_in2),
    .C_data_in3 (C_data_in3),
    .cbuf_ready (cbuf_ready),
    .cbuf_wr_en (cbuf_wr_en),
    .cbuf_index (cbuf_index),
    .cbuf_data  (cbuf_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk(input int t, input int r);
    return {32'hC0DE0000, 32'(t), 32'h0000AB00, 32'(r)};
  endfunction

  // Beat recorder and hold-stability checker, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) begin
        check("stall_wr_en", 128'(cbuf_wr_en), 128'd1);
        check("stall_index", 128'(cbuf_index), 128'(stall_idx));
        check("stall_data", cbuf_data, stall_dat);
      end
      stall_prev = cbuf_wr_en && !cbuf_ready;
      stall_idx  = cbuf_index;
      stall_dat  = cbuf_data;
      if (cbuf_wr_en && cbuf_ready) begin
        idx_q.push_back(cbuf_index);
        dat_q.push_back(cbuf_data);
        last_beat_cyc = cyc;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input int t);
    C_wr_en    = 1'b1;
    C_data_in0 = mk(t, 0);
    C_data_in1 = mk(t, 1);
    C_data_in2 = mk(t, 2);
    C_data_in3 = mk(t, 3);
  endtask

  task automatic push(input int t);
    set_push(t);
    step();
    C_wr_en = 1'b0;
  endtask

  task automatic arm(input logic [18:0] base, input logic [12:0] m);
    in_valid = 1'b1;
    C_BASE   = base;
    M_ROUND  = m;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      step();
      if (done) seen = 1'b1;
    end
    check("done_seen", 128'(seen), 128'd1);
  endtask

  task automatic check_writes(input int start, input logic [18:0] base, input int t0,
                              input int ntiles);
    int n = idx_q.size() - start;
    check("n_writes", 128'(n), 128'(4 * ntiles));
    for (int i = 0; i < n && i < 4 * ntiles; i++) begin
      logic [18:0] ei = base + 19'(i);
      check("wr_index", 128'(idx_q[start + i]), 128'(ei));
      check("wr_data", dat_q[start + i], mk(t0 + i / 4, i % 4));
    end
  endtask

  // Arms a job, pushes ntiles every gap cycles with a repeating ready pattern.
  task automatic run_job(input logic [18:0] base, input logic [12:0] m, input logic [3:0] pat,
                         input int t0, input int ntiles, input int gap);
    int  start = idx_q.size();
    logic seen = 1'b0;
    arm(base, m);
    for (int c = 0; c < 200 && !seen; c++) begin
      cbuf_ready = pat[c % 4];
      if ((c % gap == 0) && (c / gap < ntiles)) set_push(t0 + c / gap);
      else C_wr_en = 1'b0;
      step();
      if (done) seen = 1'b1;
    end
    C_wr_en = 1'b0;
    check("job_done", 128'(seen), 128'd1);
    check("done_latency", 128'(cyc), 128'(last_beat_cyc + 1));
    check("busy_after_done", 128'(busy), 128'd0);
    check("job_err", 128'(err), 128'd0);
    check_writes(start, base, t0, ntiles);
  endtask

  initial begin
    int n0;
    rst = 1'b1; in_valid = 1'b0; C_BASE = '0; M_ROUND = '0; C_wr_en = 1'b0;
    C_data_in0 = '0; C_data_in1 = '0; C_data_in2 = '0; C_data_in3 = '0;
    cbuf_ready = 1'b0;
    repeat (3) step();
    check("rst_wr_en", 128'(cbuf_wr_en), 128'd0);
    check("rst_index", 128'(cbuf_index), 128'd0);
    check("rst_data", cbuf_data, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_err", 128'(err), 128'd0);
    rst = 1'b0;
    step();

    // Push while idle: dropped, flagged, nothing written.
    n0 = idx_q.size();
    push(1);
    check("idle_push_err", 128'(err), 128'd1);
    repeat (5) step();
    check("idle_push_nowrite", 128'(idx_q.size() - n0), 128'd0);

    // Zero-tile job.
    arm(19'h10, 13'd0);
    check("m0_done", 128'(done), 128'd1);
    check("m0_busy", 128'(busy), 128'd0);
    check("m0_err_cleared", 128'(err), 128'd0);
    step();
    check("m0_done_drop", 128'(done), 128'd0);
    check("m0_busy_after", 128'(busy), 128'd0);

    // Basic, backpressure and wrap jobs.
    run_job(19'h00100, 13'd2, 4'b1111, 2, 2, 8);
    run_job(19'h00100, 13'd2, 4'b1001, 4, 2, 8);
    run_job(19'h7FFFE, 13'd1, 4'b1111, 6, 1, 8);

    // Full FIFO: third push with no pop is dropped.
    n0 = idx_q.size();
    cbuf_ready = 1'b0;
    arm(19'h00200, 13'd2);
    check("armed_busy", 128'(busy), 128'd1);
    push(10);
    repeat (7) step();
    push(11);
    repeat (7) step();
    push(12);
    check("full_drop_err", 128'(err), 128'd1);
    cbuf_ready = 1'b1;
    wait_done(100);
    check_writes(n0, 19'h00200, 10, 2);
    check("full_err_sticky", 128'(err), 128'd1);

    // Full FIFO with push coincident with head row-3 accept.
    n0 = idx_q.size();
    cbuf_ready = 1'b0;
    arm(19'h00300, 13'd3);
    push(20);
    repeat (7) step();
    push(21);
    repeat (3) step();
    cbuf_ready = 1'b1;
    repeat (3) step();
    push(22);
    check("coinc_err", 128'(err), 128'd0);
    wait_done(100);
    check_writes(n0, 19'h00300, 20, 3);
    check("coinc_err_end", 128'(err), 128'd0);

    // Reset mid-tile, then a clean job.
    n0 = idx_q.size();
    cbuf_ready = 1'b0;
    arm(19'h00400, 13'd1);
    push(30);
    cbuf_ready = 1'b1;
    step();
    rst = 1'b1;
    step();
    check("mrst_wr_en", 128'(cbuf_wr_en), 128'd0);
    check("mrst_index", 128'(cbuf_index), 128'd0);
    check("mrst_data", cbuf_data, 128'd0);
    check("mrst_busy", 128'(busy), 128'd0);
    check("mrst_done", 128'(done), 128'd0);
    check("mrst_err", 128'(err), 128'd0);
    rst = 1'b0;
    repeat (4) step();
    check("mrst_beats", 128'(idx_q.size() - n0), 128'd1);
    run_job(19'h00500, 13'd1, 4'b1111, 40, 1, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
